// File: rtl/pspin_stdout_pkg.sv
// Shared types and helpers for the PsPIN stdout collection path.
package pspin_stdout_pkg;

    localparam int unsigned STDOUT_WORD_WIDTH = 32;
    localparam int unsigned STDOUT_MAX_SRC    = 16;

    // Source index, sized for the largest supported producer count so the
    // arbiter output keeps a fixed type regardless of NUM_SRC.
    typedef logic [$clog2(STDOUT_MAX_SRC)-1:0] src_idx_t;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned fill_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pspin_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from req, search starting
// one past the last granted requester. The pointer only moves on advance.
module pspin_rr_arb
    import pspin_stdout_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output src_idx_t     grant_idx
);

    src_idx_t   ptr;
    logic [4:0] idx;
    logic       found;

    // Scan requesters in order ptr, ptr+1, ... (mod N); first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = 5'(ptr) + 5'(i);
            if (idx >= 5'(N))
                idx = idx - 5'(N);
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && idx == 5'(j)) begin
                    grant[j]  = 1'b1;
                    grant_idx = src_idx_t'(j);
                    found     = 1'b1;
                end
            end
        end
    end

    // Next search starts just after the requester that was actually served.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= (grant_idx == src_idx_t'(N - 1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/pspin_stdout_fifo.sv
// Stdout word collector: round-robin merge of NUM_SRC producer streams into a
// show-ahead FIFO read by the control-register block.
// Optional macro PSPIN_STDOUT_DROP_ON_FULL_EN: producers are never stalled;
// words granted while full are discarded and counted in dropped_words.
module pspin_stdout_fifo
    import pspin_stdout_pkg::*;
#(
    parameter  int unsigned NUM_SRC    = 2,
    parameter  int unsigned DEPTH      = 512,
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned FILL_W     = fill_w(DEPTH),
    localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      s_valid,
    input  logic [NUM_SRC*32-1:0]   s_data,
    output logic [NUM_SRC-1:0]      s_ready,
    input  logic                    stdout_rd_en,
    output logic [31:0]             stdout_dout,
    output logic                    stdout_data_valid,
    output logic [FILL_W-1:0]       fill_level,
    output logic [31:0]             dropped_words
);

    if (DATA_WIDTH != STDOUT_WORD_WIDTH) begin : g_bad_width
        $error("pspin_stdout_fifo: DATA_WIDTH must be 32");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("pspin_stdout_fifo: DEPTH must be a power of two >= 4");
    end
    if (NUM_SRC < 1 || NUM_SRC > STDOUT_MAX_SRC) begin : g_bad_src
        $error("pspin_stdout_fifo: NUM_SRC must be 1..16");
    end

    logic [NUM_SRC-1:0] grant;
    src_idx_t           grant_idx;
    logic               full;
    logic               any_grant;
    logic               push;
    logic               pop;
    logic               advance;
    logic [31:0]        push_data;
    logic [31:0]        mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [PTR_W-1:0]   rptr_n;
    logic [FILL_W-1:0]  fill_n;

    pspin_rr_arb #(.N(NUM_SRC)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (s_valid),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Full is judged on the registered level only, so a same-cycle pop never
    // reaches s_ready combinationally.
    assign full      = (fill_level == FILL_W'(DEPTH));
    assign any_grant = (|grant) && !rst;
    assign pop       = stdout_rd_en && stdout_data_valid;

`ifdef PSPIN_STDOUT_DROP_ON_FULL_EN
    logic drop;

    assign s_ready = rst ? '0 : grant;
    assign advance = any_grant;
    assign push    = any_grant && !full;
    assign drop    = any_grant && full;

    // Count discarded words, sticking at the maximum.
    always_ff @(posedge clk) begin
        if (rst)
            dropped_words <= '0;
        else if (drop && dropped_words != 32'hFFFF_FFFF)
            dropped_words <= dropped_words + 32'd1;
    end
`else
    assign s_ready       = (rst || full) ? '0 : grant;
    assign advance       = |s_ready;
    assign push          = advance;
    assign dropped_words = '0;
`endif

    // Select the granted source's word.
    always_comb begin
        push_data = '0;
        for (int k = 0; k < NUM_SRC; k++)
            if (grant_idx == src_idx_t'(k))
                push_data = s_data[32*k +: 32];
    end

    assign rptr_n = pop ? rptr + 1'b1 : rptr;
    assign fill_n = fill_level + FILL_W'(push) - FILL_W'(pop);

    // Storage array; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= push_data;
    end

    // Pointers, occupancy and the registered show-ahead head word. When the
    // FIFO is (or just became) otherwise empty, the head is the word being
    // written this cycle, so bypass it from the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr              <= '0;
            rptr              <= '0;
            fill_level        <= '0;
            stdout_data_valid <= 1'b0;
            stdout_dout       <= '0;
        end else begin
            wptr              <= wptr + PTR_W'(push);
            rptr              <= rptr_n;
            fill_level        <= fill_n;
            stdout_data_valid <= (fill_n != '0);
            if (fill_n != '0)
                stdout_dout <= (fill_level == FILL_W'(pop)) ? push_data : mem[rptr_n];
        end
    end

endmodule

// File: tb/tb_pspin_stdout_fifo.sv
// Randomized + directed bench for pspin_stdout_fifo against a queue model.
module tb_pspin_stdout_fifo;

    localparam int NS = 2;
    localparam int D  = 4;
    localparam int FW = $clog2(D + 1);
`ifdef PSPIN_STDOUT_DROP_ON_FULL_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NS-1:0]    s_valid;
    logic [NS*32-1:0] s_data;
    logic [NS-1:0]    s_ready;
    logic             stdout_rd_en;
    logic [31:0]      stdout_dout;
    logic             stdout_data_valid;
    logic [FW-1:0]    fill_level;
    logic [31:0]      dropped_words;

    pspin_stdout_fifo #(.NUM_SRC(NS), .DEPTH(D), .DATA_WIDTH(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .s_valid           (s_valid),
        .s_data            (s_data),
        .s_ready           (s_ready),
        .stdout_rd_en      (stdout_rd_en),
        .stdout_dout       (stdout_dout),
        .stdout_data_valid (stdout_data_valid),
        .fill_level        (fill_level),
        .dropped_words     (dropped_words)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q[$];
    int          last    = NS - 1;
    logic [31:0] m_drop  = 0;
    int          acc_k;
    bit          popped_v;
    logic [31:0] popped_w;
    logic [31:0] got[$];
    int          seq[NS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Round-robin: first valid source at or after last granted + 1.
    function automatic int pick();
        for (int i = 1; i <= NS; i++) begin
            int k = (last + i) % NS;
            if (s_valid[k]) return k;
        end
        return -1;
    endfunction

    // One clock: inputs were set at the preceding negedge.
    task automatic cyc();
        int k;
        bit was_full, do_pop;
        logic [NS-1:0] exp_rdy;
        acc_k    = -1;
        popped_v = 0;
        #1;
        chk("fill", 32'(fill_level), q.size());
        chk("valid", 32'(stdout_data_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("dout", stdout_dout, q[0]);
        chk("dropped", dropped_words, m_drop);
        was_full = (q.size() == D);
        k = rst ? -1 : pick();
        exp_rdy = '0;
        if (k >= 0 && (DROP || !was_full)) exp_rdy[k] = 1'b1;
        chk("ready", 32'(s_ready), 32'(exp_rdy));
        if (stdout_rd_en && stdout_data_valid) begin
            popped_v = 1;
            popped_w = stdout_dout;
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            last   = NS - 1;
            m_drop = 0;
        end else begin
            do_pop = stdout_rd_en && (q.size() != 0);
            if (k >= 0 && (DROP || !was_full)) begin
                last  = k;
                acc_k = k;
                if (was_full) begin
                    if (m_drop != 32'hFFFF_FFFF) m_drop++;
                end else
                    q.push_back(s_data[32*k +: 32]);
            end
            if (do_pop) void'(q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        int n, na, nb;
        logic [31:0] exp_list[$];

        rst = 1; s_valid = '0; s_data = '0; stdout_rd_en = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        s_valid = '1;
        cyc();                       // reset state, ready held low in reset
        s_valid = '0;
        rst = 0;

        // Single source, three back-to-back words, no reads
        for (int i = 1; i <= 3; i++) begin
            s_valid = 2'b01; s_data[31:0] = 32'hDEAD0000 + i;
            cyc();
        end
        s_valid = '0;
        cyc();
        chk("t1_fill3", 32'(fill_level), 3);
        chk("t1_head", stdout_dout, 32'hDEAD0001);

        // Three pulsed pops, then a pop on empty
        for (int i = 1; i <= 3; i++) begin
            stdout_rd_en = 1; cyc();
            chk("t2_popv", 32'(popped_v), 1);
            chk("t2_pop", popped_w, 32'hDEAD0000 + i);
            stdout_rd_en = 0; cyc();
        end
        chk("t2_empty_v", 32'(stdout_data_valid), 0);
        stdout_rd_en = 1; cyc(); stdout_rd_en = 0;
        chk("t2_underflow", 32'(fill_level), 0);

        // Round-robin from reset: both sources held valid, continuous pops
        rst = 1; cyc(); rst = 0;
        na = 0; nb = 0; got.delete();
        stdout_rd_en = 1;
        for (int c = 0; c < 30 && (na < 4 || nb < 4 || stdout_data_valid); c++) begin
            s_valid = {nb < 4, na < 4};
            s_data  = {32'hB0000000 + nb, 32'hA0000000 + na};
            cyc();
            if (acc_k == 0) na++;
            if (acc_k == 1) nb++;
            if (popped_v) got.push_back(popped_w);
        end
        s_valid = '0; stdout_rd_en = 0;
        chk("rr_n", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++)
            chk("rr_order", got[i], (i % 2 == 0) ? 32'hA0000000 + i/2 : 32'hB0000000 + i/2);

        // Full behaviour
        n = 0; got.delete();
        for (int c = 0; c < 7; c++) begin
            s_valid = 2'b01; s_data[31:0] = 32'hC0000000 + n;
            cyc();
            if (acc_k == 0) n++;
        end
        chk("full_fill", 32'(fill_level), D);
        chk("full_head", stdout_dout, 32'hC0000000);
        if (DROP) begin
            chk("drop_cnt", dropped_words, 3);
            exp_list = '{32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003};
        end else begin
            #1 chk("full_rdy0", 32'(s_ready), 0);
            stdout_rd_en = 1; cyc(); stdout_rd_en = 0;
            if (popped_v) got.push_back(popped_w);
            #1 chk("full_rdy1", 32'(s_ready), 1);
            cyc();
            if (acc_k == 0) n++;
            exp_list = '{32'hC0000000, 32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
        end
        s_valid = '0; stdout_rd_en = 1;
        for (int c = 0; c < 10 && stdout_data_valid; c++) begin
            cyc();
            if (popped_v) got.push_back(popped_w);
        end
        stdout_rd_en = 0;
        chk("full_n", got.size(), exp_list.size());
        for (int i = 0; i < exp_list.size() && i < got.size(); i++)
            chk("full_order", got[i], exp_list[i]);

        // Concurrent push + pop at fill level 2
        for (int i = 0; i < 2; i++) begin
            s_valid = 2'b10; s_data[63:32] = 32'h50000000 + i; cyc();
        end
        for (int i = 0; i < 10; i++) begin
            s_valid = 2'b10; s_data[63:32] = $urandom; stdout_rd_en = 1;
            cyc();
            chk("conc_fill", 32'(fill_level), 2);
        end
        s_valid = '0; stdout_rd_en = 0;

        // Mid-stream reset clears everything
        rst = 1; cyc(); rst = 0;
        #1;
        chk("rst_valid", 32'(stdout_data_valid), 0);
        chk("rst_fill", 32'(fill_level), 0);
        chk("rst_drop", dropped_words, 0);

        // Random traffic with hold-until-accepted producers
        for (int k = 0; k < NS; k++) seq[k] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NS; k++)
                if (!s_valid[k]) begin
                    s_valid[k] = ($urandom_range(0, 2) != 0);
                    s_data[32*k +: 32] = {4'(k), 28'(seq[k])};
                end
            stdout_rd_en = ($urandom_range(0, 3) != 0) || (c % 50 < 10 ? 1'b0 : 1'b0);
            if (c % 100 > 80) stdout_rd_en = 0;   // let it fill up
            rst = ($urandom_range(0, 79) == 0);
            cyc();
            if (acc_k >= 0) begin
                s_valid[acc_k] = 1'b0;
                seq[acc_k]++;
            end
        end
        rst = 0; s_valid = '0; stdout_rd_en = 0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
